// File: rtl/alu_div.sv
// Multi-lane signed integer divider: L lockstep lanes, restoring division on
// operand magnitudes, one quotient bit per cycle, sign fix-up on the last step.
module alu_div #(
    parameter int N = 32,
    parameter int L = 4
) (
    input  logic           phi,
    output logic           stall,
    input  logic           valid,
    input  logic [N*L-1:0] a,
    input  logic [N*L-1:0] b,
    output logic [N*L-1:0] q,
    output logic [N*L-1:0] r,
    output logic           finish,
    input  logic           reset
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT         state, nextState;
    logic [CW-1:0] count;
    logic          accept;
    logic          lastIter;

    logic [N-1:0]  remR   [L];
    logic [N-1:0]  qsR    [L];
    logic [N-1:0]  bMag   [L];
    logic [L-1:0]  negQ, negR, bZero;

    logic [N:0]    trial   [L];
    logic [N-1:0]  remNext [L];
    logic [N-1:0]  qsNext  [L];
    logic [N-1:0]  qFinal  [L];
    logic [N-1:0]  rFinal  [L];

    function automatic logic [N-1:0] absVal(input logic [N-1:0] x);
        return x[N-1] ? ('0 - x) : x;
    endfunction

    assign accept   = valid && (state != BUSY);
    assign lastIter = (count == CW'(N - 1));

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (valid) nextState = BUSY;
            BUSY: begin
                stall = 1'b1;
                if (lastIter) nextState = DONE;
            end
            DONE: begin
                finish    = 1'b1;
                nextState = valid ? BUSY : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // qsR shifts the dividend magnitude out at the top while quotient bits
    // enter at the bottom, so one register serves both roles.
    always_comb begin
        for (int unsigned i = 0; i < L; i++) begin
            trial[i]   = {remR[i], qsR[i][N-1]} - {1'b0, bMag[i]};
            remNext[i] = {remR[i][N-2:0], qsR[i][N-1]};
            qsNext[i]  = {qsR[i][N-2:0], 1'b0};
            if (!trial[i][N]) begin
                remNext[i] = trial[i][N-1:0];
                qsNext[i]  = {qsR[i][N-2:0], 1'b1};
            end
            qFinal[i] = bZero[i] ? '1 : (negQ[i] ? ('0 - qsNext[i]) : qsNext[i]);
            rFinal[i] = negR[i] ? ('0 - remNext[i]) : remNext[i];
        end
    end

    always_ff @(posedge phi) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge phi) begin
        if (reset) begin
            count <= '0;
            q     <= '0;
            r     <= '0;
            negQ  <= '0;
            negR  <= '0;
            bZero <= '0;
            for (int unsigned i = 0; i < L; i++) begin
                remR[i] <= '0;
                qsR[i]  <= '0;
                bMag[i] <= '0;
            end
        end else if (accept) begin
            count <= '0;
            for (int unsigned i = 0; i < L; i++) begin
                remR[i]  <= '0;
                qsR[i]   <= absVal(a[N*i +: N]);
                bMag[i]  <= absVal(b[N*i +: N]);
                negQ[i]  <= a[N*i+N-1] ^ b[N*i+N-1];
                negR[i]  <= a[N*i+N-1];
                bZero[i] <= (b[N*i +: N] == '0);
            end
        end else if (state == BUSY) begin
            count <= count + CW'(1);
            for (int unsigned i = 0; i < L; i++) begin
                remR[i] <= remNext[i];
                qsR[i]  <= qsNext[i];
                if (lastIter) begin
                    q[N*i +: N] <= qFinal[i];
                    r[N*i +: N] <= rFinal[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_div.sv
// Directed and randomized checks for alu_div at N=32, L=4.
module tb_alu_div;

    localparam int N = 32;
    localparam int L = 4;
    localparam int W = N * L;

    logic         phi = 1'b0;
    logic         reset = 1'b1;
    logic         valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] q, r;
    logic         stall, finish;

    int testsRun  = 0;
    int failCount = 0;

    alu_div #(.N(N), .L(L)) dut (
        .phi(phi), .stall(stall), .valid(valid), .a(a), .b(b),
        .q(q), .r(r), .finish(finish), .reset(reset)
    );

    always #5 phi = ~phi;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the divider can accept; returns at the finish cycle.
    task automatic runOp(input logic [W-1:0] aV, input logic [W-1:0] bV,
                         output logic [W-1:0] qV, output logic [W-1:0] rV,
                         output int lat, output int stalls);
        a = aV; b = bV; valid = 1'b1;
        lat = 0; stalls = 0;
        @(negedge phi);
        valid = 1'b0;
        a = ~aV; b = ~bV;
        lat = 1;
        while (!finish && lat < 100) begin
            if (stall) stalls++;
            @(negedge phi);
            lat++;
        end
        qV = q; rV = r;
    endtask

    function automatic void refLane(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] qq, output logic [31:0] rr);
        int signed xs, ys;
        xs = x; ys = y;
        if (y == 32'h0) begin
            qq = '1; rr = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            qq = 32'h8000_0000; rr = '0;
        end else begin
            qq = xs / ys; rr = xs % ys;
        end
    endfunction

    logic [W-1:0] tabA [4];
    logic [W-1:0] tabB [4];
    logic [W-1:0] tabQ [4];
    logic [W-1:0] tabR [4];

    initial begin
        logic [W-1:0] qV, rV, ea, eb, eq, er;
        logic [31:0]  lq, lr, la, lb;
        int lat, stalls, idx, cyc, lastFin;
        bit sawFinish;

        // {lane3, lane2, lane1, lane0}
        tabA[0] = 128'h00000064_FFFFFF9C_00000007_00000000;
        tabB[0] = 128'h00000007_00000007_FFFFFFFE_00000005;
        tabQ[0] = 128'h0000000E_FFFFFFF2_FFFFFFFD_00000000;
        tabR[0] = 128'h00000002_FFFFFFFE_00000001_00000000;
        tabA[1] = 128'h00000005_80000000_FFFFFFF9_00000064;
        tabB[1] = 128'h00000000_FFFFFFFF_00000000_FFFFFFFF;
        tabQ[1] = 128'hFFFFFFFF_80000000_FFFFFFFF_FFFFFF9C;
        tabR[1] = 128'h00000005_00000000_FFFFFFF9_00000000;
        tabA[2] = 128'hFFFFFFF9_7FFFFFFF_80000000_80000000;
        tabB[2] = 128'h00000002_80000000_00000001_80000000;
        tabQ[2] = 128'hFFFFFFFD_00000000_80000000_00000001;
        tabR[2] = 128'hFFFFFFFF_7FFFFFFF_00000000_00000000;
        tabA[3] = 128'h000003E8_FFFFFC18_00000001_FFFFFFFF;
        tabB[3] = 128'hFFFFFFDF_FFFFFFDF_00000003_FFFFFFFD;
        tabQ[3] = 128'hFFFFFFE2_0000001E_00000000_00000000;
        tabR[3] = 128'h0000000A_FFFFFFF6_00000001_FFFFFFFF;

        repeat (2) @(negedge phi);
        reset = 1'b0;
        checkVal("rst_stall",  W'(stall),  '0);
        checkVal("rst_finish", W'(finish), '0);
        checkVal("rst_q", q, '0);
        checkVal("rst_r", r, '0);

        for (int k = 0; k < 4; k++) begin
            runOp(tabA[k], tabB[k], qV, rV, lat, stalls);
            checkVal($sformatf("dir%0d_lat", k), W'(lat), W'(N + 1));
            checkVal($sformatf("dir%0d_stall", k), W'(stalls), W'(N));
            checkVal($sformatf("dir%0d_q", k), qV, tabQ[k]);
            checkVal($sformatf("dir%0d_r", k), rV, tabR[k]);
        end

        repeat (3) @(negedge phi);
        checkVal("hold_q", q, tabQ[3]);
        checkVal("hold_r", r, tabR[3]);
        checkVal("hold_finish", W'(finish), '0);

        // Back-to-back with valid held high; junk operands while busy.
        idx = 0; cyc = 0; lastFin = 0;
        a = tabA[0]; b = tabB[0]; valid = 1'b1;
        for (int c = 0; c < 300 && idx < 4; c++) begin
            @(negedge phi);
            cyc++;
            if (finish) begin
                checkVal($sformatf("b2b%0d_q", idx), q, tabQ[idx]);
                checkVal($sformatf("b2b%0d_r", idx), r, tabR[idx]);
                if (idx > 0) checkVal($sformatf("b2b%0d_gap", idx), W'(cyc - lastFin), W'(N + 1));
                lastFin = cyc;
                idx++;
                if (idx < 4) begin
                    a = tabA[idx]; b = tabB[idx];
                end else begin
                    valid = 1'b0;
                end
            end else begin
                a = {$urandom, $urandom, $urandom, $urandom};
                b = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        checkVal("b2b_count", W'(idx), W'(4));
        valid = 1'b0;
        @(negedge phi);

        // Reset 10 cycles into BUSY aborts without a finish pulse.
        a = tabA[0]; b = tabB[0]; valid = 1'b1;
        @(negedge phi);
        valid = 1'b0;
        repeat (9) @(negedge phi);
        reset = 1'b1;
        @(negedge phi);
        reset = 1'b0;
        checkVal("abort_stall",  W'(stall),  '0);
        checkVal("abort_finish", W'(finish), '0);
        checkVal("abort_q", q, '0);
        checkVal("abort_r", r, '0);
        sawFinish = 1'b0;
        repeat (40) begin
            @(negedge phi);
            if (finish || stall) sawFinish = 1'b1;
        end
        checkVal("abort_quiet", W'(sawFinish), '0);
        runOp(tabA[3], tabB[3], qV, rV, lat, stalls);
        checkVal("after_abort_lat", W'(lat), W'(N + 1));
        checkVal("after_abort_q", qV, tabQ[3]);
        checkVal("after_abort_r", rV, tabR[3]);
        @(negedge phi);

        // Reset wins over a simultaneous request.
        a = tabA[0]; b = tabB[0]; valid = 1'b1; reset = 1'b1;
        @(negedge phi);
        reset = 1'b0; valid = 1'b0;
        checkVal("rst_prio_stall", W'(stall), '0);
        checkVal("rst_prio_q", q, '0);

        for (int n = 0; n < 1000; n++) begin
            for (int j = 0; j < L; j++) begin
                la = $urandom;
                case ($urandom_range(0, 3))
                    0: lb = 32'($urandom_range(0, 20)) - 32'd10;
                    1: lb = 32'($urandom_range(0, 65535)) - 32'd32768;
                    default: lb = $urandom;
                endcase
                ea[N*j +: N] = la;
                eb[N*j +: N] = lb;
                refLane(la, lb, lq, lr);
                eq[N*j +: N] = lq;
                er[N*j +: N] = lr;
            end
            runOp(ea, eb, qV, rV, lat, stalls);
            checkVal($sformatf("rnd%0d_stall", n), W'(stalls), W'(N));
            checkVal($sformatf("rnd%0d_q", n), qV, eq);
            checkVal($sformatf("rnd%0d_r", n), rV, er);
            if (lat >= 100) break;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 Parameter N, default 32, lane width in bits.
REQ-002 Parameter L, default 4, number of parallel lanes.
REQ-003 phi  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  output  1  high while busy; new requests not accepted.
REQ-006 valid  input  1  request strobe, sampled on rising edge of phi.
REQ-007 a  input  N*L  dividends, lane i = bits [N*i+N-1 : N*i].
REQ-008 b  input  N*L  divisors, same lane packing as a.
REQ-009 q  output  N*L  quotients, same lane packing.
REQ-010 r  output  N*L  remainders, same lane packing.
REQ-011 finish  output  1  one-cycle pulse marking q/r valid for the last accepted request.
REQ-012 Positional port order SHALL be phi, stall, valid, a, b, q, r, finish, reset (reset last).

Function
REQ-013 Every lane SHALL perform an independent signed two's-complement N-bit division; all lanes run in lockstep.
REQ-014 Quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend, with a = q*b + r and |r| < |b|.
REQ-015 Divide by zero (b lane = 0): q lane = all ones, r lane = a lane.
REQ-016 Overflow (a = -2^(N-1), b = -1): q lane = -2^(N-1), r lane = 0.
REQ-017 Implementation SHALL be iterative, one quotient bit per cycle per lane, on operand magnitudes with sign fix-up at completion.
REQ-018 States: IDLE, BUSY (N iteration cycles), DONE (one cycle).
REQ-019 IDLE: stall=0; valid=1 at edge t latches a, b and enters BUSY.
REQ-020 BUSY: stall=1 for cycles t+1 .. t+N; valid ignored; a/b changes ignored.
REQ-021 DONE: cycle t+N+1, finish=1, stall=0, q/r updated with results.
REQ-022 valid=1 during DONE SHALL be accepted (back-to-back), i.e. throughput one request per N+1 cycles.
REQ-023 q/r SHALL hold their value from the last DONE until the next DONE.
REQ-024 finish SHALL be exactly one cycle wide and only in DONE.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, stall=0, finish=0, q=0, r=0, regardless of state.
REQ-026 reset during BUSY SHALL abort the operation with no finish pulse.
REQ-027 reset has priority over valid in the same cycle.

Verification
REQ-028 N=32, L=4; lanes a={100,-100,7,0}, b={7,7,-2,5}, valid pulse -> after 33 cycles finish=1, q={14,-14,-3,0}, r={2,-2,1,0}.
REQ-029 Lane a=5, b=0 and lane a=-2^31, b=-1 -> q=0xFFFFFFFF, r=5; q=0x80000000, r=0.
REQ-030 valid held high continuously with new operands each cycle -> one finish every 33 cycles, each result matching operands present at acceptance edge; operands changed during BUSY have no effect.
REQ-031 reset asserted 10 cycles into BUSY -> next cycle stall=0, q=r=0, no finish pulse; fresh request then completes normally.
REQ-032 Random signed operands on all lanes, 1000 requests -> q/r match reference q=a/b, r=a%b (truncating), stall high exactly 32 cycles per request.
